// File: rtl/axi_lite_sram_if.sv
// axi_lite_sram_if: AXI4-Lite read/write channels between the mem stage masters and the data SRAM.
interface axi_lite_sram_if;
    logic [63:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [63:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    modport master (
        output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
    modport slave (
        input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite slave over a 64-bit word array with byte strobes and programmable
// read/write latency; read and write FSMs run independently.
module axi_lite_sram #(
    parameter int          DEPTH_WORDS   = 1024,
    parameter logic [63:0] BASE_ADDR     = 64'h8000_0000,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 1
) (
    input logic            ACLK,
    input logic            ARESETn,
    axi_lite_sram_if.slave axi
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 3;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    r_state_t    r_state;
    w_state_t    w_state;
    logic [63:0] mem [DEPTH_WORDS];
    logic [63:0] r_addr, w_addr, w_data, r_off, w_off;
    logic [7:0]  w_strb;
    logic [3:0]  r_cnt, w_cnt;
    logic        aw_held, w_held, r_ok, w_ok, aw_hs, w_hs, commit;
    always_comb begin
        r_off = r_addr - BASE_ADDR;
        w_off = w_addr - BASE_ADDR;
        r_ok = r_addr >= BASE_ADDR && r_off < SPAN;
        w_ok = w_addr >= BASE_ADDR && w_off < SPAN;
        aw_hs = axi.AWVALID && axi.AWREADY;
        w_hs = axi.WVALID && axi.WREADY;
        commit = w_state == W_WAIT && w_cnt == 4'd0 && w_ok;
    end
    assign axi.ARREADY = r_state == R_IDLE;
    assign axi.AWREADY = w_state == W_IDLE && !aw_held;
    assign axi.WREADY  = w_state == W_IDLE && !w_held;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            r_addr <= '0;
            r_cnt <= '0;
            axi.RVALID <= 1'b0;
            axi.RDATA <= '0;
            axi.RRESP <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: if (axi.ARVALID) begin
                    r_addr <= axi.ARADDR;
                    r_cnt <= 4'(READ_LATENCY - 1);
                    r_state <= R_WAIT;
                end
                R_WAIT: if (r_cnt == 4'd0) begin
                    axi.RVALID <= 1'b1;
                    axi.RDATA <= r_ok ? mem[r_off[IW+2:3]] : '0;
                    axi.RRESP <= r_ok ? 2'b00 : 2'b10;
                    r_state <= R_RESP;
                end else r_cnt <= r_cnt - 4'd1;
                R_RESP: if (axi.RREADY) begin
                    axi.RVALID <= 1'b0;
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
    // AW and W latch independently; the FSM leaves IDLE once both are held
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            w_cnt <= '0;
            axi.BVALID <= 1'b0;
            axi.BRESP <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_addr <= axi.AWADDR;
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data <= axi.WDATA;
                        w_strb <= axi.WSTRB;
                        w_held <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        w_cnt <= 4'(WRITE_LATENCY - 1);
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: if (w_cnt == 4'd0) begin
                    axi.BVALID <= 1'b1;
                    axi.BRESP <= w_ok ? 2'b00 : 2'b10;
                    w_state <= W_RESP;
                end else w_cnt <= w_cnt - 4'd1;
                W_RESP: if (axi.BREADY) begin
                    axi.BVALID <= 1'b0;
                    aw_held <= 1'b0;
                    w_held <= 1'b0;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
    // Array is unreset; commit is gated by state so a reset before the commit edge blocks the write
    always_ff @(posedge ACLK) begin
        if (commit)
            for (int i = 0; i < 8; i++)
                if (w_strb[i]) mem[w_off[IW+2:3]][8*i +: 8] <= w_data[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_lite_sram.sv
// tb_axi_lite_sram: random and directed AXI4-Lite traffic against a cycle-level transaction model.
module tb_axi_lite_sram;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int DEPTH = 1024;
    localparam int RL = 2;
    localparam int WL = 1;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b1;
    always #5 ACLK = ~ACLK;
    axi_lite_sram_if s();
    axi_lite_sram_if s4();
    axi_lite_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(RL), .WRITE_LATENCY(WL))
        dut (.ACLK(ACLK), .ARESETn(ARESETn), .axi(s));
    axi_lite_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(4), .WRITE_LATENCY(1))
        dut4 (.ACLK(ACLK), .ARESETn(ARESETn), .axi(s4));
    int vectors = 0;
    int errors = 0;
    logic [63:0] mm [DEPTH];
    bit m_rbusy, m_rvalid, m_wbusy, m_aw, m_w, m_bvalid;
    logic [63:0] m_rdata, m_raddr, m_waddr, m_wdata;
    logic [1:0] m_rresp, m_bresp;
    logic [7:0] m_wstrb;
    longint cyc = 0, m_rcap = 0, m_wcommit = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic bit in_rng(input logic [63:0] a);
        return a >= BASE && (a - BASE) < 64'(DEPTH) * 64'd8;
    endfunction
    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction
    // Model: outputs after each edge, stepped with the inputs that the next edge will see
    initial forever begin
        @(negedge ACLK);
        if (!ARESETn) begin
            m_rbusy = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00;
            m_wbusy = 0; m_aw = 0; m_w = 0; m_bvalid = 0; m_bresp = 2'b00;
        end
        chk("arready", s.ARREADY, !m_rbusy);
        chk("rvalid", s.RVALID, m_rvalid);
        if (m_rvalid) begin
            chk("rdata", s.RDATA, m_rdata);
            chk("rresp", s.RRESP, m_rresp);
        end
        chk("awready", s.AWREADY, !m_wbusy && !m_aw);
        chk("wready", s.WREADY, !m_wbusy && !m_w);
        chk("bvalid", s.BVALID, m_bvalid);
        if (m_bvalid) chk("bresp", s.BRESP, m_bresp);
        if (ARESETn) begin
            cyc++;
            if (m_rvalid) begin
                if (s.RREADY) begin m_rvalid = 0; m_rbusy = 0; end
            end else if (m_rbusy) begin
                if (cyc == m_rcap) begin
                    m_rvalid = 1;
                    if (in_rng(m_raddr)) begin m_rdata = mm[widx(m_raddr)]; m_rresp = 2'b00; end
                    else begin m_rdata = '0; m_rresp = 2'b10; end
                end
            end else if (s.ARVALID) begin
                m_rbusy = 1; m_raddr = s.ARADDR; m_rcap = cyc + RL;
            end
            if (m_bvalid) begin
                if (s.BREADY) begin m_bvalid = 0; m_wbusy = 0; m_aw = 0; m_w = 0; end
            end else if (m_wbusy) begin
                if (cyc == m_wcommit) begin
                    m_bvalid = 1;
                    m_bresp = in_rng(m_waddr) ? 2'b00 : 2'b10;
                    if (in_rng(m_waddr))
                        for (int i = 0; i < 8; i++)
                            if (m_wstrb[i]) mm[widx(m_waddr)][8*i +: 8] = m_wdata[8*i +: 8];
                end
            end else begin
                if (!m_aw && s.AWVALID) begin m_aw = 1; m_waddr = s.AWADDR; end
                if (!m_w && s.WVALID) begin m_w = 1; m_wdata = s.WDATA; m_wstrb = s.WSTRB; end
                if (m_aw && m_w) begin m_wbusy = 1; m_wcommit = cyc + WL; end
            end
        end
    end
    task automatic rd(input logic [63:0] a, output logic [63:0] d, output logic [1:0] r, output int lat);
        bit hs = 0, got = 0;
        d = '0; r = 2'b00; lat = 0;
        s.ARADDR = a; s.ARVALID = 1;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge ACLK); hs = s.ARREADY;
            @(posedge ACLK); #1;
        end
        s.ARVALID = 0; s.RREADY = 1;
        for (int n = 0; n < 40 && hs && !got; n++) begin
            @(negedge ACLK);
            if (s.RVALID) begin got = 1; d = s.RDATA; r = s.RRESP; end
            @(posedge ACLK); #1;
            if (!got) lat++;
        end
        s.RREADY = 0;
        if (!got) begin
            vectors++; errors++;
            $display("FAIL rd_timeout addr %h: got no RVALID, required RVALID", a);
        end
    endtask
    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] st, output logic [1:0] r);
        bit ah = 0, wh = 0, got = 0;
        r = 2'b00;
        s.AWADDR = a; s.AWVALID = 1; s.WDATA = d; s.WSTRB = st; s.WVALID = 1;
        for (int n = 0; n < 20 && !(ah && wh); n++) begin
            @(negedge ACLK);
            if (s.AWVALID && s.AWREADY) ah = 1;
            if (s.WVALID && s.WREADY) wh = 1;
            @(posedge ACLK); #1;
            if (ah) s.AWVALID = 0;
            if (wh) s.WVALID = 0;
        end
        s.AWVALID = 0; s.WVALID = 0; s.BREADY = 1;
        for (int n = 0; n < 40 && ah && wh && !got; n++) begin
            @(negedge ACLK);
            if (s.BVALID) begin got = 1; r = s.BRESP; end
            @(posedge ACLK); #1;
        end
        s.BREADY = 0;
        if (!got) begin
            vectors++; errors++;
            $display("FAIL wr_timeout addr %h: got no BVALID, required BVALID", a);
        end
    endtask
    function automatic logic [63:0] rnd_addr();
        int c = $urandom_range(9);
        logic [63:0] lo = 64'($urandom_range(7));
        if (c == 0) return 64'h7FFF_FFF8 + lo;
        if (c == 1) return 64'h8000_2000 + lo;
        if (c == 2) return BASE + 64'h1FF8 + lo;
        return BASE + 64'(8 * $urandom_range(15)) + lo;
    endfunction
    initial begin
        logic [63:0] d, w0;
        logic [1:0] r;
        int lat, aw_n, w_n;
        bit arh, awh, wh, got;
        s.ARADDR = '0; s.ARVALID = 0; s.RREADY = 0; s.AWADDR = '0; s.AWVALID = 0;
        s.WDATA = '0; s.WSTRB = '0; s.WVALID = 0; s.BREADY = 0;
        s4.ARADDR = '0; s4.ARVALID = 0; s4.RREADY = 0; s4.AWADDR = '0; s4.AWVALID = 0;
        s4.WDATA = '0; s4.WSTRB = '0; s4.WVALID = 0; s4.BREADY = 0;
        #1 ARESETn = 0;
        #1;
        chk("rst_rvalid", s.RVALID, 0);
        chk("rst_bvalid", s.BVALID, 0);
        chk("rst_rdata", s.RDATA, 0);
        chk("rst_arready", s.ARREADY, 1);
        chk("rst_awready", s.AWREADY, 1);
        chk("rst_wready", s.WREADY, 1);
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1;
        w0 = {$urandom, $urandom};
        wr(BASE, w0, 8'hFF, r);
        for (int k = 1; k < 16; k++) wr(BASE + 64'(8 * k), {$urandom, $urandom}, 8'hFF, r);
        wr(BASE + 64'h1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, r);
        wr(BASE + 64'h100, 64'h5555_6666_7777_8888, 8'hFF, r);
        wr(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, r);
        chk("t1_bresp", r, 2'b00);
        rd(64'h8000_0010, d, r, lat);
        chk("t1_rdata", d, 64'h1122_3344_5566_7788);
        chk("t1_rresp", r, 2'b00);
        chk("t1_latency", lat, 2);
        wr(64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, r);
        rd(64'h8000_0010, d, r, lat);
        chk("t2_strobe_rdata", d, 64'h1122_3344_AAAA_AAAA);
        wr(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, r);
        chk("strb0_bresp", r, 2'b00);
        rd(64'h8000_0010, d, r, lat);
        chk("strb0_rdata", d, 64'h1122_3344_AAAA_AAAA);
        s.WDATA = 64'hDEAD_BEEF_0123_4567; s.WSTRB = 8'hFF; s.WVALID = 1;
        @(posedge ACLK); #1; s.WVALID = 0;
        repeat (3) begin
            @(negedge ACLK);
            chk("t3_wready_low", s.WREADY, 0);
            chk("t3_awready_high", s.AWREADY, 1);
            @(posedge ACLK); #1;
        end
        s.AWADDR = 64'h8000_0018; s.AWVALID = 1;
        @(posedge ACLK); #1; s.AWVALID = 0; s.BREADY = 1;
        @(negedge ACLK); chk("t3_bvalid_early", s.BVALID, 0);
        @(posedge ACLK); #1;
        @(negedge ACLK); chk("t3_bvalid", s.BVALID, 1); chk("t3_bresp", s.BRESP, 2'b00);
        @(posedge ACLK); #1; s.BREADY = 0;
        rd(64'h8000_0018, d, r, lat);
        chk("t3_rdata", d, 64'hDEAD_BEEF_0123_4567);
        rd(64'h7FFF_FFF8, d, r, lat);
        chk("t4_oor_rresp", r, 2'b10);
        chk("t4_oor_rdata", d, 0);
        wr(64'h8000_2000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, r);
        chk("t4_oor_bresp", r, 2'b10);
        rd(BASE, d, r, lat);
        chk("t4_word0_kept", d, w0);
        rd(BASE + 64'h1FF8, d, r, lat);
        chk("t4_last_word", d, 64'h0123_4567_89AB_CDEF);
        chk("t4_last_rresp", r, 2'b00);
        s4.AWADDR = BASE + 64'h40; s4.AWVALID = 1; s4.WDATA = 64'hCAFE_F00D_1234_5678;
        s4.WSTRB = 8'hFF; s4.WVALID = 1; s4.BREADY = 1;
        @(posedge ACLK); #1; s4.AWVALID = 0; s4.WVALID = 0;
        repeat (3) @(posedge ACLK);
        #1 s4.BREADY = 0;
        s4.ARADDR = BASE + 64'h40; s4.ARVALID = 1;
        @(posedge ACLK); #1; s4.ARVALID = 0;
        lat = 0; got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge ACLK);
            if (s4.RVALID) got = 1;
            else begin
                chk("t5_arready_wait", s4.ARREADY, 0);
                @(posedge ACLK); #1; lat++;
            end
        end
        chk("t5_latency", lat, 4);
        for (int k = 0; k < 6; k++) begin
            chk("t5_rvalid_hold", s4.RVALID, 1);
            chk("t5_rdata_hold", s4.RDATA, 64'hCAFE_F00D_1234_5678);
            chk("t5_arready_hold", s4.ARREADY, 0);
            @(posedge ACLK); #1;
            @(negedge ACLK);
        end
        @(posedge ACLK); #1; s4.RREADY = 1;
        @(posedge ACLK); #1; s4.RREADY = 0;
        @(negedge ACLK);
        chk("t5_rvalid_done", s4.RVALID, 0);
        chk("t5_arready_done", s4.ARREADY, 1);
        @(posedge ACLK); #1;
        aw_n = 0; w_n = 0;
        for (int c = 0; c < 2060; c++) begin
            @(negedge ACLK);
            arh = s.ARVALID && s.ARREADY;
            awh = s.AWVALID && s.AWREADY;
            wh = s.WVALID && s.WREADY;
            @(posedge ACLK); #1;
            if (arh) s.ARVALID = 0;
            if (awh) s.AWVALID = 0;
            if (wh) s.WVALID = 0;
            if (c < 2000) begin
                if (!s.ARVALID && $urandom_range(2) == 0) begin s.ARADDR = rnd_addr(); s.ARVALID = 1; end
                if (!s.AWVALID && aw_n <= w_n && $urandom_range(2) == 0) begin
                    s.AWADDR = rnd_addr(); s.AWVALID = 1; aw_n++;
                end
                if (!s.WVALID && w_n <= aw_n && $urandom_range(2) == 0) begin
                    s.WDATA = {$urandom, $urandom}; s.WSTRB = 8'($urandom); s.WVALID = 1; w_n++;
                end
                s.RREADY = 1'($urandom); s.BREADY = 1'($urandom);
            end else begin
                if (!s.AWVALID && aw_n < w_n) begin s.AWADDR = rnd_addr(); s.AWVALID = 1; aw_n++; end
                if (!s.WVALID && w_n < aw_n) begin s.WDATA = '1; s.WSTRB = 8'hFF; s.WVALID = 1; w_n++; end
                s.RREADY = 1; s.BREADY = 1;
            end
        end
        chk("drain_idle", {s.ARVALID, s.AWVALID, s.WVALID}, 3'b000);
        s.ARVALID = 0; s.AWVALID = 0; s.WVALID = 0; s.RREADY = 0; s.BREADY = 0;
        repeat (3) @(posedge ACLK);
        #1;
        s.ARADDR = BASE + 64'h100; s.ARVALID = 1;
        @(posedge ACLK); #1; s.ARVALID = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("t6_rvalid_before", s.RVALID, 1);
        ARESETn = 0;
        #1;
        chk("t6_rvalid_async", s.RVALID, 0);
        chk("t6_rdata_async", s.RDATA, 0);
        @(posedge ACLK); #1; ARESETn = 1;
        s.ARADDR = BASE + 64'h100; s.ARVALID = 1;
        s.AWADDR = BASE + 64'h100; s.AWVALID = 1;
        s.WDATA = 64'hFFFF_0000_FFFF_0000; s.WSTRB = 8'hFF; s.WVALID = 1;
        @(posedge ACLK); #1;
        s.ARVALID = 0; s.AWVALID = 0; s.WVALID = 0;
        ARESETn = 0;
        #1;
        chk("t6_rvalid_rst", s.RVALID, 0);
        chk("t6_bvalid_rst", s.BVALID, 0);
        chk("t6_arready_rst", s.ARREADY, 1);
        chk("t6_awready_rst", s.AWREADY, 1);
        chk("t6_wready_rst", s.WREADY, 1);
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1;
        rd(BASE + 64'h100, d, r, lat);
        chk("t6_word_kept", d, 64'h5555_6666_7777_8888);
        chk("t6_rresp", r, 2'b00);
        chk("t6_latency", lat, 2);
        repeat (3) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
